// File: rtl/traffic_pkg.sv
// Shared intersection types: sensor channel state encoding and the light
// encoding used by the downstream traffic-light controller.
package traffic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b001,
      ST_PRESENT = 3'b010,
      ST_HOLD    = 3'b100
   } sensor_state_t;

   localparam logic [1:0] GREEN  = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] RED    = 2'b10;

endpackage

// File: rtl/sensor_channel.sv
// One street's sensor path: two-flop synchroniser, debounce filter,
// presence/hold FSM and a saturating car counter with a per-car pulse.
module sensor_channel
   import traffic_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 4,
   parameter int unsigned HOLD     = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sensor_raw,
   input  logic             clear_count,
   output logic             traffic,
   output logic [CNT_W-1:0] count,
   output logic             car
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);
   localparam int unsigned HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic            sync_q1;
   logic            sync_q2;
   logic            filt;
   logic [DB_W-1:0] db_cnt;
   sensor_state_t   state;
   sensor_state_t   state_d;
   logic [HC_W-1:0] hold_cnt;
   logic [HC_W-1:0] hold_cnt_d;
   logic            new_car_c;

   // Synchroniser for the asynchronous raw sensor
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= sensor_raw;
         sync_q2 <= sync_q1;
      end
   end

   // Debounce: filtered level follows only after DEBOUNCE consecutive mismatches
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         filt   <= 1'b0;
         db_cnt <= '0;
      end else if (sync_q2 == filt) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
         filt   <= sync_q2;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_d;
         hold_cnt <= hold_cnt_d;
      end
   end

   // Re-entry from HOLD is checked before hold expiry
   always_comb begin
      state_d    = state;
      hold_cnt_d = hold_cnt;
      new_car_c  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (filt) begin
               state_d   = ST_PRESENT;
               new_car_c = 1'b1;
            end
         end
         ST_PRESENT: begin
            if (!filt) begin
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
            end
         end
         ST_HOLD: begin
            if (filt) begin
               state_d   = ST_PRESENT;
               new_car_c = 1'b1;
            end else if (hold_cnt == HC_W'(HOLD - 1)) begin
               state_d = ST_IDLE;
            end else begin
               hold_cnt_d = hold_cnt + HC_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign traffic = (state != ST_IDLE);

   // Clear beats a same-edge increment; the pulse still fires
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         car   <= 1'b0;
         count <= '0;
      end else begin
         car <= new_car_c;
         if (clear_count) begin
            count <= '0;
         end else if (new_car_c && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions both street car sensors into the TA/TB presence flags for the
// light controller, with per-street car counts and car pulses.
module traffic_sensor_conditioner #(
   parameter int unsigned DEBOUNCE = 4,
   parameter int unsigned HOLD     = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sensor_a_raw,
   input  logic             sensor_b_raw,
   input  logic             clear_counts,
   output logic             TA,
   output logic             TB,
   output logic [CNT_W-1:0] count_a,
   output logic [CNT_W-1:0] count_b,
   output logic             car_a,
   output logic             car_b
);

   sensor_channel #(
      .DEBOUNCE (DEBOUNCE),
      .HOLD     (HOLD),
      .CNT_W    (CNT_W)
   ) u_chan_a (
      .clock       (clock),
      .reset       (reset),
      .sensor_raw  (sensor_a_raw),
      .clear_count (clear_counts),
      .traffic     (TA),
      .count       (count_a),
      .car         (car_a)
   );

   sensor_channel #(
      .DEBOUNCE (DEBOUNCE),
      .HOLD     (HOLD),
      .CNT_W    (CNT_W)
   ) u_chan_b (
      .clock       (clock),
      .reset       (reset),
      .sensor_raw  (sensor_b_raw),
      .clear_count (clear_counts),
      .traffic     (TB),
      .count       (count_b),
      .car         (car_b)
   );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: two configurations driven in parallel,
// checked every cycle against a sample-history model plus literal timing pins.
module tb_traffic_sensor_conditioner;

   localparam int NC = 4;
   localparam int P_D[NC]   = '{4, 4, 2, 2};
   localparam int P_H[NC]   = '{8, 8, 3, 3};
   localparam int P_MAX[NC] = '{255, 255, 3, 3};

   logic       clock = 1'b0;
   logic       reset;
   logic       sensor_a_raw;
   logic       sensor_b_raw;
   logic       clear_counts;

   logic       ta0, tb0, car_a0, car_b0;
   logic [7:0] cnt_a0, cnt_b0;
   logic       ta1, tb1, car_a1, car_b1;
   logic [1:0] cnt_a1, cnt_b1;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   always #5 clock = ~clock;

   traffic_sensor_conditioner #(.DEBOUNCE(4), .HOLD(8), .CNT_W(8)) u_dut0 (
      .clock(clock), .reset(reset), .sensor_a_raw(sensor_a_raw), .sensor_b_raw(sensor_b_raw),
      .clear_counts(clear_counts), .TA(ta0), .TB(tb0), .count_a(cnt_a0), .count_b(cnt_b0),
      .car_a(car_a0), .car_b(car_b0));

   traffic_sensor_conditioner #(.DEBOUNCE(2), .HOLD(3), .CNT_W(2)) u_dut1 (
      .clock(clock), .reset(reset), .sensor_a_raw(sensor_a_raw), .sensor_b_raw(sensor_b_raw),
      .clear_counts(clear_counts), .TA(ta1), .TB(tb1), .count_a(cnt_a1), .count_b(cnt_b1),
      .car_a(car_a1), .car_b(car_b1));

   // Model state: raw samples and filtered level per edge since reset
   bit raw_q[NC][$];
   bit f_q[NC][$];
   int m_cnt[NC];
   bit exp_t[NC];
   bit exp_car[NC];

   function automatic bit s_at(int c, int e);
      if (e - 3 < 0) return 1'b0;
      return raw_q[c][e-3];
   endfunction

   function automatic bit f_after(int c, int e);
      if (e < 1) return 1'b0;
      return f_q[c][e-1];
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NC; c++) begin
            raw_q[c].delete();
            f_q[c].delete();
            m_cnt[c]   = 0;
            exp_t[c]   = 1'b0;
            exp_car[c] = 1'b0;
         end
      end else begin
         for (int c = 0; c < NC; c++) begin
            int e;
            bit fp, flip, t, cr;
            raw_q[c].push_back((c % 2 == 0) ? sensor_a_raw : sensor_b_raw);
            e  = raw_q[c].size();
            fp = f_after(c, e - 1);
            flip = 1'b1;
            for (int j = e - P_D[c] + 1; j <= e; j++)
               if (s_at(c, j) == fp) flip = 1'b0;
            f_q[c].push_back(flip ? !fp : fp);
            t = 1'b0;
            for (int j = e - P_H[c]; j <= e; j++)
               if (f_after(c, j - 1)) t = 1'b1;
            exp_t[c] = t;
            cr = f_after(c, e - 1) && !f_after(c, e - 2);
            exp_car[c] = cr;
            if (clear_counts) m_cnt[c] = 0;
            else if (cr && m_cnt[c] < P_MAX[c]) m_cnt[c] = m_cnt[c] + 1;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clock) begin
      if (cmp_en) begin
         int at[NC], ac[NC], an[NC];
         string nm[NC];
         nm = '{"i0.A", "i0.B", "i1.A", "i1.B"};
         at = '{int'(ta0), int'(tb0), int'(ta1), int'(tb1)};
         ac = '{int'(car_a0), int'(car_b0), int'(car_a1), int'(car_b1)};
         an = '{int'(cnt_a0), int'(cnt_b0), int'(cnt_a1), int'(cnt_b1)};
         for (int c = 0; c < NC; c++) begin
            check({nm[c], ".flag"},  at[c], int'(exp_t[c]));
            check({nm[c], ".car"},   ac[c], int'(exp_car[c]));
            check({nm[c], ".count"}, an[c], m_cnt[c]);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic clear_pulse();
      clear_counts = 1'b1;
      cyc(1);
      clear_counts = 1'b0;
   endtask

   int run_a, run_b, pulses, drops, chg;

   initial begin
      reset = 1'b1;
      sensor_a_raw = 1'b0;
      sensor_b_raw = 1'b0;
      clear_counts = 1'b0;
      cyc(3);
      reset  = 1'b0;
      cmp_en = 1'b1;

      // Asynchronous mid-cycle reset, then quiet window
      sensor_a_raw = 1'b1;
      cyc(10);
      check("pre_reset_TA", int'(ta0), 1);
      @(posedge clock);
      #3 reset = 1'b1;
      #1;
      check("async_reset_TA", int'(ta0), 0);
      check("async_reset_count_a", int'(cnt_a0), 0);
      check("async_reset_i1_count_a", int'(cnt_a1), 0);
      sensor_a_raw = 1'b0;
      cyc(2);
      reset = 1'b0;
      chg = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (ta0 || tb0 || car_a0 || car_b0 || cnt_a0 != 0 || cnt_b0 != 0) chg++;
      end
      check("post_reset_quiet", chg, 0);

      // Single car on A, 20 cycles
      sensor_a_raw = 1'b1;
      cyc(6);
      check("single_TA_edge6", int'(ta0), 0);
      cyc(1);
      check("single_TA_edge7", int'(ta0), 1);
      check("single_car_edge7", int'(car_a0), 1);
      check("single_count_edge7", int'(cnt_a0), 1);
      check("model_flag_edge7", int'(exp_t[0]), 1);
      check("model_count_edge7", m_cnt[0], 1);
      cyc(1);
      check("single_car_edge8", int'(car_a0), 0);
      cyc(12);
      sensor_a_raw = 1'b0;
      cyc(14);
      check("single_TA_edge34", int'(ta0), 1);
      cyc(1);
      check("single_TA_edge35", int'(ta0), 0);
      check("model_flag_edge35", int'(exp_t[0]), 0);
      check("single_TB_idle", int'(tb0), 0);
      cyc(5);

      // Glitch on B, 3 cycles
      sensor_b_raw = 1'b1;
      cyc(3);
      sensor_b_raw = 1'b0;
      chg = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (tb0 || car_b0 || cnt_b0 != 0) chg++;
      end
      check("glitch_B_no_change", chg, 0);

      // Re-entry during HOLD
      clear_pulse();
      cyc(5);
      sensor_a_raw = 1'b1;
      pulses = 0;
      drops  = 0;
      for (int i = 1; i <= 50; i++) begin
         cyc(1);
         if (car_a0) pulses++;
         if (i >= 7 && !ta0) drops++;
         if (i == 20) sensor_a_raw = 1'b0;
         if (i == 24) sensor_a_raw = 1'b1;
      end
      check("reentry_TA_drops", drops, 0);
      check("reentry_pulses", pulses, 2);
      check("reentry_count_a", int'(cnt_a0), 2);
      sensor_a_raw = 1'b0;
      cyc(20);

      // Saturation on the 2-bit instance, then clear coinciding with a car
      clear_pulse();
      for (int k = 0; k < 4; k++) begin
         sensor_a_raw = 1'b1;
         cyc(12);
         sensor_a_raw = 1'b0;
         cyc(20);
      end
      check("sat_i1_count_a", int'(cnt_a1), 3);
      check("sat_i0_count_a", int'(cnt_a0), 4);
      sensor_a_raw = 1'b1;
      cyc(4);
      clear_counts = 1'b1;
      cyc(1);
      clear_counts = 1'b0;
      check("clear_i1_count_a", int'(cnt_a1), 0);
      check("clear_i1_car_a", int'(car_a1), 1);
      check("clear_i1_TA", int'(ta1), 1);
      cyc(2);
      check("clear_i0_count_a", int'(cnt_a0), 1);
      check("clear_i0_car_a", int'(car_a0), 1);
      cyc(5);
      sensor_a_raw = 1'b0;
      cyc(20);

      // Simultaneous cars
      clear_pulse();
      sensor_a_raw = 1'b1;
      sensor_b_raw = 1'b1;
      cyc(6);
      check("simul_edge6", int'(ta0) + int'(tb0), 0);
      cyc(1);
      check("simul_TA", int'(ta0), 1);
      check("simul_TB", int'(tb0), 1);
      check("simul_count_a", int'(cnt_a0), 1);
      check("simul_count_b", int'(cnt_b0), 1);
      sensor_a_raw = 1'b0;
      sensor_b_raw = 1'b0;
      cyc(20);

      // Randomised runs of varying length, including sub-debounce glitches
      run_a = 1;
      run_b = 1;
      for (int i = 0; i < 3000; i++) begin
         cyc(1);
         run_a = run_a - 1;
         if (run_a == 0) begin
            sensor_a_raw = !sensor_a_raw;
            run_a = int'($urandom_range(1, 24));
         end
         run_b = run_b - 1;
         if (run_b == 0) begin
            sensor_b_raw = !sensor_b_raw;
            run_b = int'($urandom_range(1, 24));
         end
         clear_counts = ($urandom_range(0, 39) == 0);
      end
      clear_counts = 1'b0;
      sensor_b_raw = 1'b0;

      // Reset with the sensor held high: counted as a new car after release
      sensor_a_raw = 1'b1;
      cyc(10);
      @(posedge clock);
      #3 reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(6);
      check("rst_high_TA_edge6", int'(ta0), 0);
      cyc(1);
      check("rst_high_TA_edge7", int'(ta0), 1);
      check("rst_high_count_a", int'(cnt_a0), 1);
      check("rst_high_car_a", int'(car_a0), 1);
      sensor_a_raw = 1'b0;
      cyc(20);

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
